// File: rtl/ahb_addr_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ahb_addr_decoder
//
// Address-phase half of an AHB-Lite slave interconnect. Decodes haddr into a
// one-hot slave select for the response mux, and hosts a built-in default
// slave that answers transfers to unmapped addresses with the two-cycle AHB
// ERROR response. The address of the most recent fault and a saturating fault
// count are kept for debug.
//
// Parameters
//   SLAVE_DEVISES_CNT  number of mapped slaves
//   SLV_BASE           packed base addresses, slave i at [32*i+31:32*i]
//   SLV_MASK           packed match masks, same layout as SLV_BASE
//   ERR_CNT_W          width of the fault counter
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   haddr         in   AHB address (address phase)
//   htrans        in   AHB transfer type
//   hready        in   bus-level HREADY from the slave response mux
//   err_clr       in   synchronous clear of err_cnt / err_valid
//   hsel_s        out  one-hot slave select (combinational, from haddr only)
//   def_readyout  out  default-slave HREADYOUT
//   def_resp      out  default-slave HRESP
//   err_valid     out  sticky flag: a fault occurred since reset or clear
//   err_addr      out  haddr of the most recent faulting transfer
//   err_cnt       out  saturating fault count
// -----------------------------------------------------------------------------
module ahb_addr_decoder #(
    parameter int                               SLAVE_DEVISES_CNT = 2,
    parameter logic [SLAVE_DEVISES_CNT*32-1:0]  SLV_BASE          = {32'h0001_0000, 32'h0000_0000},
    parameter logic [SLAVE_DEVISES_CNT*32-1:0]  SLV_MASK          = {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int                               ERR_CNT_W         = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   haddr,
    input  logic [1:0]                    htrans,
    input  logic                          hready,
    input  logic                          err_clr,
    output logic [SLAVE_DEVISES_CNT-1:0]  hsel_s,
    output logic                          def_readyout,
    output logic                          def_resp,
    output logic                          err_valid,
    output logic [31:0]                   err_addr,
    output logic [ERR_CNT_W-1:0]          err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } def_state_e;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [SLAVE_DEVISES_CNT-1:0] match_raw;
    logic [SLAVE_DEVISES_CNT-1:0] hsel_comb;
    logic                         found;

    genvar gi;
    generate
        for (gi = 0; gi < SLAVE_DEVISES_CNT; gi++) begin : g_match
            assign match_raw[gi] =
                ((haddr & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32]);
        end
    endgenerate

    // Overlapping regions: the lowest index wins, so the select stays one-hot.
    always_comb begin
        hsel_comb = '0;
        found     = 1'b0;
        for (int i = 0; i < SLAVE_DEVISES_CNT; i++) begin
            if (match_raw[i] && !found) begin
                hsel_comb[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign hsel_s = hsel_comb;

    // -------------------------------------------------------------------------
    // Transfer qualification
    // -------------------------------------------------------------------------
    logic unmapped;
    logic accept;
    logic fault;

    // htrans[1] alone separates NONSEQ/SEQ from IDLE/BUSY.
    logic unused_htrans0;
    assign unused_htrans0 = htrans[0];

    assign unmapped = ~|hsel_comb;
    assign accept   = hready & htrans[1];
    assign fault    = accept & unmapped;

    // -------------------------------------------------------------------------
    // Default slave FSM
    // -------------------------------------------------------------------------
    def_state_e state_q, state_d;
    logic       readyout_q, readyout_d;
    logic       resp_q, resp_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            D_IDLE:  if (fault) state_d = D_ERR1;
            D_ERR1:  state_d = D_ERR2;
            // A new fault accepted in the last ERROR cycle restarts the
            // response without passing through idle.
            D_ERR2:  state_d = fault ? D_ERR1 : D_IDLE;
            default: state_d = D_IDLE;
        endcase

        // Outputs are registered alongside the state, so they are decoded
        // from the next state here.
        readyout_d = (state_d != D_ERR1);
        resp_d     = (state_d != D_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= D_IDLE;
            readyout_q <= 1'b1;
            resp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            readyout_q <= readyout_d;
            resp_q     <= resp_d;
        end
    end

    assign def_readyout = readyout_q;
    assign def_resp     = resp_q;

    // -------------------------------------------------------------------------
    // Debug registers
    // -------------------------------------------------------------------------
    logic                 err_valid_q, err_valid_d;
    logic [31:0]          err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W-1:0] cnt_base;

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_cnt_d   = err_cnt_q;

        // A fault in the same cycle as a clear counts from zero, so the
        // fault is never lost to the clear.
        cnt_base = err_clr ? '0 : err_cnt_q;

        if (fault) begin
            err_valid_d = 1'b1;
            err_addr_d  = haddr;
            err_cnt_d   = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_ONE;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
            err_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/ahb_addr_decoder.md
Name: ahb_addr_decoder

Overview:
- Address-phase side of the AHB-Lite slave interconnect.
- Decodes haddr into one-hot hsel_s for the slave response mux.
- Contains a built-in default slave that returns the two-cycle AHB ERROR response for transfers to unmapped addresses.
- Records the last faulting address and a saturating fault count for debug.

Parameters:
- SLAVE_DEVISES_CNT, `SLAVE_DEVISES_CNT (2): number of mapped slaves.
- SLV_BASE, {32'h0001_0000, 32'h0000_0000}: packed SLAVE_DEVISES_CNT*32 base addresses; slave i uses bits [32*i+31:32*i].
- SLV_MASK, {32'hFFFF_0000, 32'hFFFF_0000}: packed match masks, same layout as SLV_BASE.
- ERR_CNT_W, 8: width of the fault counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- haddr  in  32  AHB address (address phase)
- htrans  in  2  AHB transfer type
- hready  in  1  bus-level HREADY returned by the slave mux
- err_clr  in  1  synchronous clear of err_cnt and err_valid
- hsel_s  out  SLAVE_DEVISES_CNT  one-hot slave select
- def_readyout  out  1  default-slave HREADYOUT
- def_resp  out  1  default-slave HRESP
- err_valid  out  1  sticky: at least one fault since reset or clear
- err_addr  out  32  haddr of the most recent faulting transfer
- err_cnt  out  ERR_CNT_W  saturating fault count

Behaviour:
- Decode:
  - hsel_s is combinational and independent of htrans.
  - hsel_s[i] = ((haddr & MASK_i) == BASE_i).
  - If regions overlap, only the lowest matching index is set; hsel_s is always one-hot or zero.
- unmapped = (hsel_s == 0).
- Accept condition: hready && htrans[1] (NONSEQ or SEQ).
  - IDLE and BUSY transfers never fault, including those to unmapped addresses.
- Default-slave FSM; next state is registered, outputs decode from state:
  - D_IDLE: def_readyout=1, def_resp=0. Accept && unmapped -> D_ERR1. Otherwise stay.
  - D_ERR1: def_readyout=0, def_resp=1. Unconditionally -> D_ERR2.
  - D_ERR2: def_readyout=1, def_resp=1. Accept && unmapped -> D_ERR1 (back-to-back fault). Otherwise -> D_IDLE.
- Timing: the first ERROR cycle is the cycle after the address phase; the full error response takes exactly 2 data-phase cycles.
- Mapped accepted transfers do not touch the FSM or the debug registers.
- Integration: def_readyout and def_resp are the data-phase response source whenever no mapped slave holds the data phase. The mux default branch is driven by them.
- Debug registers, updated on every accept of an unmapped transfer:
  - err_addr <= haddr.
  - err_valid <= 1.
  - err_cnt <= err_cnt+1, saturating at 2^ERR_CNT_W-1 with no wrap.
- err_clr: err_cnt <= 0 and err_valid <= 0; err_addr is kept.
  - err_clr in the same cycle as a new fault: err_cnt=1, err_valid=1, err_addr updated (fault wins over clear).
- Reset, asynchronous, may occur mid-error:
  - FSM -> D_IDLE immediately.
  - def_readyout=1, def_resp=0.
  - err_valid=0, err_addr=0, err_cnt=0.
- Outputs never show X after reset release. hsel_s follows haddr only.

Test Plan:
- Decode: haddr=0x0000_1234 -> hsel_s=2'b01; haddr=0x0001_0008 -> 2'b10; haddr=0x0002_0000 -> 2'b00. In all three cases def_readyout stays 1.
- Single fault: NONSEQ to 0x0003_0000 with hready=1 -> next cycle readyout=0/resp=1, following cycle readyout=1/resp=1, then 1/0. Afterwards err_addr=0x0003_0000, err_cnt=1, err_valid=1.
- Non-faulting transfer types: IDLE and BUSY to 0x0003_0000, and NONSEQ with hready=0 -> FSM stays D_IDLE and err_cnt is unchanged.
- Back-to-back: second NONSEQ to 0x0004_0000 accepted in D_ERR2 -> pattern 0/1, 1/1, 0/1, 1/1, then 1/0. err_cnt=2, err_addr=0x0004_0000.
- Saturation and clear:
  - 260 unmapped faults -> err_cnt=255.
  - err_clr alone -> err_cnt=0, err_valid=0, err_addr retained.
  - err_clr together with a fault -> err_cnt=1.
- Reset in D_ERR1: assert rst_n=0 mid-cycle -> def_readyout=1 and def_resp=0 immediately (before the next clock edge), all error registers 0.
